// File: rtl/leaf_lane_dispatcher.sv
// Packet-level round-robin dispatcher feeding N_LANES leaf lanes from one valid/ready stream.
// Optional per-lane packet counters are built when LEAF_DISPATCH_STATS_EN is defined.
module leaf_lane_dispatcher #(
  parameter int DATA_W  = 32,
  parameter int N_LANES = 5,
  parameter int CNT_W   = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [N_LANES-1:0]  lane_en,
  output logic [N_LANES-1:0]  out_valid,
  input  logic [N_LANES-1:0]  out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                busy
`ifdef LEAF_DISPATCH_STATS_EN
  ,
  input  logic                stats_clr,
  output logic [N_LANES*CNT_W-1:0] pkt_count
`endif
);

  localparam int LANE_W = $clog2(N_LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OFFER  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e              state_r;
  state_e              state_n_s;
  logic [LANE_W-1:0]   cur_lane_r;
  logic [LANE_W-1:0]   lane_n_s;
  logic                hold_valid_r;
  logic [DATA_W-1:0]   hold_data_r;
  logic                hold_last_r;
  logic                lane_ok_s;
  logic                offer_s;
  logic                out_fire_s;
  logic                last_fire_s;
  logic                in_fire_s;

  // Lane index increment; wraps by explicit compare so non-power-of-2 lane counts work.
  function automatic logic [LANE_W-1:0] wrap_inc(input logic [LANE_W-1:0] idx);
    if (idx == LANE_W'(N_LANES - 1)) begin
      wrap_inc = {LANE_W{1'b0}};
    end else begin
      wrap_inc = idx + LANE_W'(1);
    end
  endfunction

  // First enabled lane strictly after cur (wrapping back to cur itself); holds cur when mask is empty.
  function automatic logic [LANE_W-1:0] next_enabled(input logic [LANE_W-1:0] cur,
                                                     input logic [N_LANES-1:0] mask);
    logic [LANE_W-1:0] idx;
    logic              found;
    idx          = cur;
    found        = 1'b0;
    next_enabled = cur;
    for (int i = 0; i < N_LANES; i++) begin
      idx = wrap_inc(idx);
      if (!found && mask[idx]) begin
        next_enabled = idx;
        found        = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  assign lane_ok_s   = lane_en[cur_lane_r];
  assign out_fire_s  = |(out_valid & out_ready);
  assign last_fire_s = out_fire_s & hold_last_r;
  assign in_ready    = rst_n & (~hold_valid_r | out_fire_s);
  assign in_fire_s   = in_valid & in_ready;
  assign out_data    = hold_data_r;
  assign out_last    = hold_last_r;
  assign busy        = (state_r != IDLE) | hold_valid_r;

  // One-hot offer toward the current lane; once past IDLE the lane mask no longer gates it.
  always_comb begin
    offer_s   = 1'b0;
    out_valid = {N_LANES{1'b0}};
    offer_s   = hold_valid_r & (((state_r == IDLE) & lane_ok_s) | (state_r != IDLE));
    if (offer_s) begin
      out_valid = {{(N_LANES-1){1'b0}}, 1'b1} << cur_lane_r;
    end else begin
      out_valid = {N_LANES{1'b0}};
    end
  end

  // Next-state and lane selection; the lane is only re-chosen at packet boundaries or while idle.
  always_comb begin
    state_n_s = state_r;
    lane_n_s  = cur_lane_r;
    case (state_r)
      IDLE: begin
        if (offer_s) begin
          if (last_fire_s) begin
            state_n_s = IDLE;
            lane_n_s  = next_enabled(cur_lane_r, lane_en);
          end else if (out_fire_s) begin
            state_n_s = ACTIVE;
          end else begin
            state_n_s = OFFER;
          end
        end else if (!lane_ok_s && (|lane_en)) begin
          lane_n_s = next_enabled(cur_lane_r, lane_en);
        end else begin
          lane_n_s = cur_lane_r;
        end
      end
      OFFER, ACTIVE: begin
        if (last_fire_s) begin
          state_n_s = IDLE;
          lane_n_s  = next_enabled(cur_lane_r, lane_en);
        end else if (out_fire_s) begin
          state_n_s = ACTIVE;
        end else begin
          state_n_s = state_r;
        end
      end
      default: begin
        state_n_s = IDLE;
        lane_n_s  = {LANE_W{1'b0}};
      end
    endcase
  end

  // State, lane pointer and 1-deep holding register; fill wins over drain so throughput stays 1 beat/cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cur_lane_r   <= {LANE_W{1'b0}};
      hold_valid_r <= 1'b0;
      hold_data_r  <= {DATA_W{1'b0}};
      hold_last_r  <= 1'b0;
    end else begin
      state_r    <= state_n_s;
      cur_lane_r <= lane_n_s;
      if (in_fire_s) begin
        hold_valid_r <= 1'b1;
        hold_data_r  <= in_data;
        hold_last_r  <= in_last;
      end else if (out_fire_s) begin
        hold_valid_r <= 1'b0;
      end else begin
        hold_valid_r <= hold_valid_r;
      end
    end
  end

`ifdef LEAF_DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_r [N_LANES];

  // Saturating per-lane completed-packet counters; clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANES; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else if (stats_clr) begin
      for (int i = 0; i < N_LANES; i++) cnt_r[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        if (last_fire_s && (cur_lane_r == LANE_W'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
          cnt_r[i] <= cnt_r[i] + CNT_W'(1);
        end else begin
          cnt_r[i] <= cnt_r[i];
        end
      end
    end
  end

  // Flatten counters onto the output bus, lane i at [i*CNT_W +: CNT_W].
  always_comb begin
    pkt_count = {(N_LANES*CNT_W){1'b0}};
    for (int i = 0; i < N_LANES; i++) begin
      pkt_count[i*CNT_W +: CNT_W] = cnt_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_leaf_lane_dispatcher.sv
// Self-checking bench for leaf_lane_dispatcher: directed scenarios plus randomized traffic
// checked against a packet-level reference model (stats checks when LEAF_DISPATCH_STATS_EN is defined).
module tb_leaf_lane_dispatcher;

  localparam int NL = 5;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [NL-1:0] lane_en;
  logic [NL-1:0] out_valid;
  logic [NL-1:0] out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
`ifdef LEAF_DISPATCH_STATS_EN
  logic             stats_clr;
  logic [NL*CW-1:0] pkt_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  leaf_lane_dispatcher #(.DATA_W(DW), .N_LANES(NL), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .lane_en(lane_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
`ifdef LEAF_DISPATCH_STATS_EN
    , .stats_clr(stats_clr), .pkt_count(pkt_count)
`endif
  );

  // Round-robin rule from the lane's point of view: first enabled lane after cur, modulo NL.
  function automatic int next_lane_after(int cur, logic [NL-1:0] m);
    for (int k = 1; k <= NL; k++) begin
      if (m[(cur + k) % NL]) return (cur + k) % NL;
    end
    return cur;
  endfunction

  // Returns at a falling edge with reset just released; that cycle is cycle 0 for the caller.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = '1;
`ifdef LEAF_DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    lane_en = 5'b11111;
    do_reset();
    in_valid = 1'b1; in_data = 32'hA5A5_0001; in_last = 1'b0; out_ready = 5'b00000;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL reset_pre_busy: got %b want 1", busy); end
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_data = 32'h0000_0BAD;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready); end
    @(negedge clk);
    #1;
    vectors++;
    if ({out_valid, out_data, out_last, busy, in_ready} !== {5'b0, 32'h0, 1'b0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_values: got ov=%b d=%h l=%b busy=%b ir=%b want all zero",
               out_valid, out_data, out_last, busy, in_ready);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    @(negedge clk);
  endtask

  task automatic test_single_beats();
    lane_en = 5'b11111;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      in_valid = (k < 5); in_data = 32'h1000 + k; in_last = 1'b1; out_ready = '1;
      #1;
      if (k < 5) begin
        vectors++;
        if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_in_ready[%0d]: got %b want 1", k, in_ready); end
      end
      if (k >= 1) begin
        vectors++;
        if (out_valid !== (5'b00001 << (k - 1)) || out_data !== 32'h1000 + k - 1) begin
          miscompares++;
          $display("FAIL single_lane[%0d]: got ov=%b d=%h want ov=%b d=%h", k, out_valid, out_data,
                   5'b00001 << (k - 1), 32'h1000 + k - 1);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_multi_beat();
    logic [NL-1:0] exp_ov [5];
    lane_en = 5'b11111;
    exp_ov = '{5'b0, 5'b00001, 5'b00001, 5'b00001, 5'b00010};
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      in_valid = (k < 4); in_data = 32'h2000 + k; in_last = (k >= 2); out_ready = '1;
      #1;
      if (k >= 1) begin
        vectors++;
        if (out_valid !== exp_ov[k] || out_data !== 32'h2000 + k - 1 || out_last !== (k >= 3)) begin
          miscompares++;
          $display("FAIL multi_beat[%0d]: got ov=%b d=%h l=%b want ov=%b d=%h l=%b", k, out_valid,
                   out_data, out_last, exp_ov[k], 32'h2000 + k - 1, (k >= 3));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mask();
    logic [NL-1:0] exp_ov [4];
    exp_ov = '{5'b0, 5'b00100, 5'b10000, 5'b00100};
    lane_en = 5'b10100;
    do_reset();
    for (int k = 0; k <= 3; k++) begin
      in_valid = (k < 3); in_data = 32'h3000 + k; in_last = 1'b1; out_ready = '1;
      #1;
      if (k >= 1) begin
        vectors++;
        if (out_valid !== exp_ov[k] || out_data !== 32'h3000 + k - 1) begin
          miscompares++;
          $display("FAIL mask_lane[%0d]: got ov=%b d=%h want ov=%b d=%h", k, out_valid, out_data,
                   exp_ov[k], 32'h3000 + k - 1);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    lane_en = 5'b11111;
    do_reset();
    in_valid = 1'b1; in_data = 32'h4000_00AA; in_last = 1'b1; out_ready = 5'b00000;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_first_accept: got %b want 1", in_ready); end
    @(negedge clk);
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 32'h4000_00BB; in_last = 1'b1; out_ready = 5'b11110;
      lane_en = (k >= 2) ? 5'b11110 : 5'b11111;
      #1;
      vectors++;
      if (out_valid !== 5'b00001 || out_data !== 32'h4000_00AA || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got ov=%b d=%h ir=%b want ov=00001 d=400000aa ir=0", k,
                 out_valid, out_data, in_ready);
      end
      @(negedge clk);
    end
    out_ready = 5'b11111;
    #1;
    vectors++;
    if (out_valid !== 5'b00001 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_release: got ov=%b ir=%b want ov=00001 ir=1", out_valid, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 5'b00010 || out_data !== 32'h4000_00BB) begin
      miscompares++;
      $display("FAIL stall_next_lane: got ov=%b d=%h want ov=00010 d=400000bb", out_valid, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet();
    lane_en = 5'b11111;
    do_reset();
    for (int k = 0; k <= 4; k++) begin
      in_valid = 1'b1; in_last = (k == 3); in_data = 32'h5000 + k; out_ready = '1;
      rst_n = (k != 2);
      if (k == 3) in_data = 32'h5555_0000;
      if (k == 4) in_valid = 1'b0;
      #1;
      if (k == 1) begin
        vectors++;
        if (out_valid !== 5'b00001 || out_data !== 32'h5000) begin
          miscompares++; $display("FAIL rstmid_beat0: got ov=%b d=%h want ov=00001 d=00005000", out_valid, out_data);
        end
      end
      if (k == 2) begin
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rstmid_in_ready: got %b want 0", in_ready); end
      end
      if (k == 3) begin
        vectors++;
        if (out_valid !== 5'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL rstmid_after: got ov=%b busy=%b ir=%b want ov=00000 busy=0 ir=1", out_valid, busy, in_ready);
        end
      end
      if (k == 4) begin
        vectors++;
        if (out_valid !== 5'b00001 || out_data !== 32'h5555_0000) begin
          miscompares++; $display("FAIL rstmid_next_pkt: got ov=%b d=%h want ov=00001 d=55550000", out_valid, out_data);
        end
      end
      @(negedge clk);
    end
  endtask

`ifdef LEAF_DISPATCH_STATS_EN
  task automatic test_stats();
    lane_en = 5'b00001;
    do_reset();
    for (int k = 0; k <= 6; k++) begin
      in_valid = (k < 5); in_data = 32'h6000 + k; in_last = 1'b1; out_ready = '1;
      stats_clr = (k == 5);
      #1;
      if (k == 5) begin
        vectors++;
        if (pkt_count !== 10'b00_00_00_00_11 || out_valid !== 5'b00001) begin
          miscompares++; $display("FAIL stats_saturate: got cnt=%b ov=%b want cnt=0000000011 ov=00001", pkt_count, out_valid);
        end
      end
      if (k == 6) begin
        vectors++;
        if (pkt_count !== 10'b0) begin miscompares++; $display("FAIL stats_clear: got %b want 0", pkt_count); end
      end
      @(negedge clk);
    end
    stats_clr = 1'b0;
  endtask
`endif

  task automatic test_random();
    logic [NL-1:0] m, ov, exp_ov;
    int model_lane, occ, beats_left, cyc;
    bit mid_pkt, have_beat, fire, ir;
    logic [DW-1:0] qd[$];
    logic ql[$];
    logic [DW-1:0] cur_d;
    logic cur_l;
    for (int phase = 0; phase < 4; phase++) begin
      m = 5'($urandom_range(1, 31));
      lane_en = m;
      do_reset();
      model_lane = next_lane_after(NL - 1, m);
      occ = 0; mid_pkt = 0; have_beat = 0; beats_left = 0; cur_d = '0; cur_l = 1'b0;
      qd.delete(); ql.delete();
      for (cyc = 0; cyc < 340; cyc++) begin
        if (!have_beat && (cyc < 300 || beats_left > 0) && $urandom_range(0, 9) < 7) begin
          if (beats_left == 0) beats_left = $urandom_range(1, 4);
          cur_d = $urandom; cur_l = (beats_left == 1); have_beat = 1;
        end
        in_valid = have_beat; in_data = have_beat ? cur_d : $urandom; in_last = have_beat ? cur_l : 1'b0;
        out_ready = (cyc < 300) ? 5'($urandom) : 5'b11111;
        #1;
        ov = out_valid; ir = in_ready; fire = |(ov & out_ready);
        exp_ov = (occ != 0) ? (5'b00001 << model_lane) : 5'b0;
        vectors++;
        if (ov !== exp_ov) begin
          miscompares++; $display("FAIL rand_out_valid[p%0d c%0d]: got %b want %b", phase, cyc, ov, exp_ov);
        end
        vectors++;
        if (ir !== (occ == 0 || fire)) begin
          miscompares++; $display("FAIL rand_in_ready[p%0d c%0d]: got %b want %b", phase, cyc, ir, (occ == 0 || fire));
        end
        vectors++;
        if (busy !== (occ != 0 || mid_pkt)) begin
          miscompares++; $display("FAIL rand_busy[p%0d c%0d]: got %b want %b", phase, cyc, busy, (occ != 0 || mid_pkt));
        end
        if (occ != 0) begin
          vectors++;
          if (out_data !== qd[0] || out_last !== ql[0]) begin
            miscompares++;
            $display("FAIL rand_data[p%0d c%0d]: got d=%h l=%b want d=%h l=%b", phase, cyc, out_data, out_last, qd[0], ql[0]);
          end
        end
        if (fire && occ != 0) begin
          if (ql[0]) begin mid_pkt = 0; model_lane = next_lane_after(model_lane, m); end
          else mid_pkt = 1;
          void'(qd.pop_front()); void'(ql.pop_front());
          occ--;
        end
        if (in_valid && ir) begin
          qd.push_back(in_data); ql.push_back(in_last);
          occ++; have_beat = 0; beats_left--;
        end
        @(negedge clk);
      end
      vectors++;
      if (qd.size() != 0 || beats_left != 0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL rand_drain[p%0d]: got pending=%0d left=%0d busy=%b want 0 0 0", phase, qd.size(), beats_left, busy);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; lane_en = '1; out_ready = '1;
`ifdef LEAF_DISPATCH_STATS_EN
    stats_clr = 1'b0;
`endif
    test_reset();
    test_single_beats();
    test_multi_beat();
    test_mask();
    test_stall();
    test_reset_mid_packet();
`ifdef LEAF_DISPATCH_STATS_EN
    test_stats();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
